fir_coeff_loader: RTL
=====================

Name: fir_coeff_loader

Overview:
- Producer side of the FIR coefficient write bus (coeffs_wren/coeffs_addr/coeffs_wdata).
- Accepts one complete coefficient set as an AXI-stream frame into a shadow buffer and validates its length.
- Once the filter has no samples in flight, replays the set as back-to-back coefficient writes, so the filter never runs on a partial or malformed set.

Parameters:
- NUMBER_TAPS, 16, coefficients per set; must be ≥2; equals the filter's tap count.
- COEFFICIENT_WIDTH, 16, bits per coefficient.
- REVERSE_ORDER, 0, 0: stream beat i is written to address i. 1: stream beat i is written to address NUMBER_TAPS-1-i.

Ports:
- clock  input  1  single clock, shared with the filter.
- reset  input  1  synchronous, active-high.
- coeffs_in_tdata  input  COEFFICIENT_WIDTH  coefficient beat.
- coeffs_in_tvalid  input  1  beat valid.
- coeffs_in_tlast  input  1  last beat of set.
- coeffs_in_tready  output  1  loader accepts beat.
- filter_busy  input  1  high while the filter holds samples (driven from samples_remaining).
- coeffs_wren  output  1  coefficient write strobe.
- coeffs_addr  output  $clog2(NUMBER_TAPS)  coefficient write address.
- coeffs_wdata  output  COEFFICIENT_WIDTH  coefficient write data.
- load_done  output  1  one-cycle pulse after a set is fully committed.
- load_error  output  1  one-cycle pulse when a malformed frame ends.
- error_code  output  2  01 = short frame, 10 = long frame; holds the last error value.
- coeffs_loaded  output  1  sticky; set on the first successful commit.

Behaviour:
- Reset values: all outputs 0; state RECEIVE; beat count 0. Shadow buffer contents are not cleared.
- A beat transfers when coeffs_in_tvalid & coeffs_in_tready. tvalid gaps are allowed; all state advances only on transfers.
- State RECEIVE (tready=1):
  - Each transfer writes shadow[count] and increments count.
  - tlast with count==NUMBER_TAPS-1: go to WAIT_IDLE.
  - tlast with count<NUMBER_TAPS-1: pulse load_error, error_code=01, count=0, stay in RECEIVE.
  - No tlast with count==NUMBER_TAPS-1: store the beat, go to DRAIN.
- State DRAIN (tready=1):
  - Discard beats; the shadow buffer is not written.
  - On the tlast transfer: pulse load_error, error_code=10, count=0, go to RECEIVE.
- Malformed frames never drive coeffs_wren. The shadow buffer may be partially overwritten, but it is never committed.
- State WAIT_IDLE (tready=0):
  - On the first edge where filter_busy==0 is sampled, go to COMMIT with idx=0.
  - If filter_busy is already low on entry, the commit starts on the next edge.
- State COMMIT (tready=0):
  - Outputs are registered. If filter_busy is sampled low at edge k, coeffs_wren=1 for cycles k+1 through k+NUMBER_TAPS, contiguously.
  - coeffs_addr runs 0..NUMBER_TAPS-1 in order.
  - coeffs_wdata = shadow[addr] (REVERSE_ORDER=0) or shadow[NUMBER_TAPS-1-addr] (REVERSE_ORDER=1).
  - filter_busy is ignored once COMMIT has started.
- Completion, cycle k+NUMBER_TAPS+1:
  - coeffs_wren=0; coeffs_addr and coeffs_wdata are 0.
  - load_done pulses for one cycle; coeffs_loaded is set.
  - State returns to RECEIVE and tready=1 in the same cycle.
- Whenever coeffs_wren=0, coeffs_addr and coeffs_wdata are driven to 0.
- Latency: from the tlast transfer of a valid set (filter idle) to the first write is 2 cycles.
- error_code changes only together with a load_error pulse.
- load_done and load_error are never high in the same cycle.
- Reset mid-operation:
  - Outputs go to 0 on the next edge and the loader restarts in RECEIVE.
  - If reset lands during COMMIT, the filter may hold a partially written set. Software must reload in that case.
  - coeffs_loaded is cleared.
- Width: count and idx use $clog2(NUMBER_TAPS) bits and never wrap within a valid frame. DRAIN does not count beats.

Test Plan:
- Basic commit: NUMBER_TAPS=4, REVERSE_ORDER=0, beats 1,2,3,4 with tlast on 4, filter_busy=0. Expect wren for 4 contiguous cycles with (addr,data) = (0,1),(1,2),(2,3),(3,4); load_done 1 cycle; coeffs_loaded=1; tready low from the cycle after tlast until load_done.
- Short frame: beats 7,8,9 with tlast on 9. Expect load_error pulse, error_code=01, no wren. A following 4-beat frame 5,6,7,8 then commits normally.
- Long frame: 6 beats with tlast on beat 6. Expect tready held high through beat 6, load_error after beat 6, error_code=10, no wren.
- Busy hold-off: filter_busy=1 for 10 cycles after a valid frame. Expect tready=0 and wren=0 throughout; the first write occurs the cycle after filter_busy is sampled low.
- Reverse order: REVERSE_ORDER=1, beats 1,2,3,4. Expect (addr,data) = (0,4),(1,3),(2,2),(3,1).
- Reset mid-commit: reset asserted after 2 writes. Expect wren=0 on the next cycle, tready=1 after reset is released, coeffs_loaded=0, no load_done; a fresh frame commits correctly.

Source files
------------

// File: rtl/fir_coeff_loader_if.sv
// Coefficient loader bus: AXI-stream coefficient input, filter status and coefficient write port.
// Latency: none (wires only).
// Backpressure: coeffs_in_tready from the loader; the write side has no backpressure.
// Ports: master = coefficient source / filter side, slave = loader.
interface fir_coeff_loader_if #(
    parameter int NUMBER_TAPS       = 16,
    parameter int COEFFICIENT_WIDTH = 16
);
    localparam int ADDR_WIDTH = $clog2(NUMBER_TAPS);

    // Coefficient stream
    logic [COEFFICIENT_WIDTH-1:0] coeffs_in_tdata;
    logic                         coeffs_in_tvalid;
    logic                         coeffs_in_tlast;
    logic                         coeffs_in_tready;

    // Filter status
    logic                         filter_busy;

    // Coefficient write bus toward the filter
    logic                         coeffs_wren;
    logic [ADDR_WIDTH-1:0]        coeffs_addr;
    logic [COEFFICIENT_WIDTH-1:0] coeffs_wdata;

    // Status
    logic                         load_done;
    logic                         load_error;
    logic [1:0]                   error_code;
    logic                         coeffs_loaded;

    modport master (
        output coeffs_in_tdata, coeffs_in_tvalid, coeffs_in_tlast, filter_busy,
        input  coeffs_in_tready, coeffs_wren, coeffs_addr, coeffs_wdata,
        input  load_done, load_error, error_code, coeffs_loaded
    );

    modport slave (
        input  coeffs_in_tdata, coeffs_in_tvalid, coeffs_in_tlast, filter_busy,
        output coeffs_in_tready, coeffs_wren, coeffs_addr, coeffs_wdata,
        output load_done, load_error, error_code, coeffs_loaded
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Shadow-buffers one FIR coefficient set from a stream, validates its length, commits it when the filter is idle.
// Latency: first coefficient write 2 cycles after the tlast beat of a valid set (filter idle).
// Backpressure: tready high in RECEIVE/DRAIN, low while waiting for the filter and while committing.
// Ports: clock, reset (sync, active-high), bus (slave modport of fir_coeff_loader_if).
module fir_coeff_loader #(
    parameter int NUMBER_TAPS       = 16,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter bit REVERSE_ORDER     = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    fir_coeff_loader_if.slave    bus
);
    localparam int              ADDR_WIDTH = $clog2(NUMBER_TAPS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUMBER_TAPS - 1);

    typedef enum logic [1:0] {
        RECEIVE   = 2'd0,
        DRAIN     = 2'd1,
        WAIT_IDLE = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    state_t                       state, state_next;
    logic [ADDR_WIDTH-1:0]        count, count_next;
    logic [ADDR_WIDTH-1:0]        idx, idx_next;
    logic [ADDR_WIDTH-1:0]        rd_idx;
    logic [COEFFICIENT_WIDTH-1:0] shadow [NUMBER_TAPS];

    logic                         xfer;
    logic                         commit_end;

    logic                         wren_q, wren_next;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_next;
    logic [COEFFICIENT_WIDTH-1:0] wdata_q, wdata_next;
    logic                         done_q, done_next;
    logic                         error_q, error_next;
    logic [1:0]                   code_q, code_next;
    logic                         loaded_q, loaded_next;

    // tready is held low during reset so nothing is accepted before the loader is running.
    assign bus.coeffs_in_tready = ((state == RECEIVE) || (state == DRAIN)) && !reset;
    assign xfer                 = bus.coeffs_in_tvalid && bus.coeffs_in_tready;

    // The last write of a commit is visible on the registered outputs; the edge after it finishes.
    assign commit_end = wren_q && (addr_q == LAST_IDX);
    assign rd_idx     = REVERSE_ORDER ? (LAST_IDX - idx) : idx;

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RECEIVE;
            count <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            idx   <= idx_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        count_next = count;
        idx_next   = idx;
        case (state)
            RECEIVE: begin
                if (xfer) begin
                    if (bus.coeffs_in_tlast) begin
                        count_next = '0;
                        if (count == LAST_IDX) begin
                            state_next = WAIT_IDLE;
                        end
                    end else if (count == LAST_IDX) begin
                        // Full set seen without tlast: everything further belongs to a long frame.
                        count_next = '0;
                        state_next = DRAIN;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (xfer && bus.coeffs_in_tlast) begin
                    state_next = RECEIVE;
                end
            end
            WAIT_IDLE: begin
                if (!bus.filter_busy) begin
                    state_next = COMMIT;
                    idx_next   = '0;
                end
            end
            COMMIT: begin
                if (commit_end) begin
                    state_next = RECEIVE;
                end else if (idx != LAST_IDX) begin
                    // idx parks on the last address instead of wrapping.
                    idx_next = idx + 1'b1;
                end
            end
            default: state_next = RECEIVE;
        endcase
    end

    // ---------------- output logic (next values of registered outputs) ----------------
    always_comb begin
        wren_next   = 1'b0;
        addr_next   = '0;
        wdata_next  = '0;
        done_next   = 1'b0;
        error_next  = 1'b0;
        code_next   = code_q;
        loaded_next = loaded_q;
        case (state)
            RECEIVE: begin
                if (xfer && bus.coeffs_in_tlast && (count != LAST_IDX)) begin
                    error_next = 1'b1;
                    code_next  = 2'b01;
                end
            end
            DRAIN: begin
                if (xfer && bus.coeffs_in_tlast) begin
                    error_next = 1'b1;
                    code_next  = 2'b10;
                end
            end
            COMMIT: begin
                if (commit_end) begin
                    done_next   = 1'b1;
                    loaded_next = 1'b1;
                end else begin
                    wren_next  = 1'b1;
                    addr_next  = idx;
                    wdata_next = shadow[rd_idx];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 2'b00;
            loaded_q <= 1'b0;
        end else begin
            wren_q   <= wren_next;
            addr_q   <= addr_next;
            wdata_q  <= wdata_next;
            done_q   <= done_next;
            error_q  <= error_next;
            code_q   <= code_next;
            loaded_q <= loaded_next;
        end
    end

    // Shadow buffer is never cleared; a malformed frame may overwrite it but is never committed.
    always_ff @(posedge clock) begin
        if ((state == RECEIVE) && xfer) begin
            shadow[count] <= bus.coeffs_in_tdata;
        end
    end

    assign bus.coeffs_wren   = wren_q;
    assign bus.coeffs_addr   = addr_q;
    assign bus.coeffs_wdata  = wdata_q;
    assign bus.load_done     = done_q;
    assign bus.load_error    = error_q;
    assign bus.error_code    = code_q;
    assign bus.coeffs_loaded = loaded_q;
endmodule
